// File: rtl/sram_wb_ctrl_if.sv
// Wishbone-classic slave and fetch-stream signals shared between sram_wb_ctrl and its requesters.
`timescale 1ns/1ps
interface sram_wb_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WMASKS = 4
);
  logic                  wbs_cyc_i;
  logic                  wbs_stb_i;
  logic                  wbs_we_i;
  logic [NUM_WMASKS-1:0] wbs_sel_i;
  logic [31:0]           wbs_adr_i;
  logic [DATA_WIDTH-1:0] wbs_dat_i;
  logic                  wbs_ack_o;
  logic [DATA_WIDTH-1:0] wbs_dat_o;
  logic                  fetch_req_i;
  logic [ADDR_WIDTH-1:0] fetch_addr_i;
  logic                  fetch_ready_o;
  logic                  fetch_valid_o;
  logic [DATA_WIDTH-1:0] fetch_data_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  fetch_req_i, fetch_addr_i,
    output fetch_ready_o, fetch_valid_o, fetch_data_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output fetch_req_i, fetch_addr_i,
    input  fetch_ready_o, fetch_valid_o, fetch_data_o
  );
endinterface

// File: rtl/sram_wb_ctrl.sv
// Initiator for a 1RW+1R OpenRAM macro: Wishbone cycles on port 0, pipelined fetch reads on port 1.
// Optional SRAM_CTRL_COLLISION_EN stalls a fetch that would be sampled with a same-word port-0 write.
`timescale 1ns/1ps
module sram_wb_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WMASKS = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  sram_wb_ctrl_if.slave         bus,
  output logic                  csb0_o,
  output logic                  web0_o,
  output logic [NUM_WMASKS-1:0] wmask0_o,
  output logic [ADDR_WIDTH-1:0] addr0_o,
  output logic [DATA_WIDTH-1:0] din0_o,
  input  logic [DATA_WIDTH-1:0] dout0_i,
  output logic                  csb1_o,
  output logic [ADDR_WIDTH-1:0] addr1_o,
  input  logic [DATA_WIDTH-1:0] dout1_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                state_q, state_d;
  logic                  abort_q, abort_d;
  logic                  csb0_d, web0_d, ack_d;
  logic [NUM_WMASKS-1:0] wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_d;
  logic [DATA_WIDTH-1:0] din0_d, wb_dat_d;
  logic                  ready_q;
  logic                  fetch_pend_q;
  logic                  fetch_accept_c;
  logic [ADDR_WIDTH-1:0] word_addr_c;
  logic                  wb_req_c;
  logic                  unused_adr_c;

  assign word_addr_c  = bus.wbs_adr_i[ADDR_WIDTH+1:2];
  assign unused_adr_c = ^{bus.wbs_adr_i[31:ADDR_WIDTH+2], bus.wbs_adr_i[1:0]};
  // The ack cycle still shows the old strobe; it must not start a second access.
  assign wb_req_c     = bus.wbs_cyc_i & bus.wbs_stb_i & ~bus.wbs_ack_o;

`ifdef SRAM_CTRL_COLLISION_EN
  logic collide_c;
  assign collide_c = (state_q == IDLE) & wb_req_c & bus.wbs_we_i & bus.fetch_req_i &
                     (bus.fetch_addr_i == word_addr_c);
  assign bus.fetch_ready_o = ready_q & ~collide_c;
`else
  assign bus.fetch_ready_o = ready_q;
`endif

  assign fetch_accept_c = bus.fetch_req_i & bus.fetch_ready_o;

  // Port-0 next state and next register values.
  always_comb begin
    state_d  = state_q;
    abort_d  = abort_q;
    csb0_d   = csb0_o;
    web0_d   = web0_o;
    wmask0_d = wmask0_o;
    addr0_d  = addr0_o;
    din0_d   = din0_o;
    ack_d    = 1'b0;
    wb_dat_d = bus.wbs_dat_o;
    case (state_q)
      IDLE: begin
        if (wb_req_c) begin
          csb0_d   = 1'b0;
          web0_d   = ~bus.wbs_we_i;
          wmask0_d = bus.wbs_we_i ? bus.wbs_sel_i : '0;
          addr0_d  = word_addr_c;
          din0_d   = bus.wbs_dat_i;
          abort_d  = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        csb0_d = 1'b1;
        if (!bus.wbs_cyc_i) abort_d = 1'b1;
        state_d = web0_o ? WAIT : ACK;
      end
      WAIT: begin
        wb_dat_d = dout0_i;
        if (!bus.wbs_cyc_i) abort_d = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        ack_d   = ~abort_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      abort_q       <= 1'b0;
      csb0_o        <= 1'b1;
      web0_o        <= 1'b1;
      wmask0_o      <= '0;
      addr0_o       <= '0;
      din0_o        <= '0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
    end else begin
      state_q       <= state_d;
      abort_q       <= abort_d;
      csb0_o        <= csb0_d;
      web0_o        <= web0_d;
      wmask0_o      <= wmask0_d;
      addr0_o       <= addr0_d;
      din0_o        <= din0_d;
      bus.wbs_ack_o <= ack_d;
      bus.wbs_dat_o <= wb_dat_d;
    end
  end

  // Fetch pipeline: issue, SRAM sample, capture after the read negedge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ready_q           <= 1'b0;
      csb1_o            <= 1'b1;
      addr1_o           <= '0;
      fetch_pend_q      <= 1'b0;
      bus.fetch_valid_o <= 1'b0;
      bus.fetch_data_o  <= '0;
    end else begin
      ready_q           <= 1'b1;
      csb1_o            <= ~fetch_accept_c;
      if (fetch_accept_c) addr1_o <= bus.fetch_addr_i;
      fetch_pend_q      <= ~csb1_o;
      bus.fetch_valid_o <= fetch_pend_q;
      if (fetch_pend_q) bus.fetch_data_o <= dout1_i;
    end
  end

endmodule
